// File: rtl/byteblast_fetch_core.sv
// ---------------------------------------------------------------------------
// byteblast_fetch_core
//
// Instruction-fetch front end of the ByteBlast8 CPU. It contains three parts:
//   - a one-hot fetch/decode/execute phase sequencer;
//   - a program counter that advances on the edge that ends a FETCH phase;
//   - a single-port word RAM addressed by the program counter.
//
// Ports:
//   clk        in   single clock, all state updates on the rising edge
//   reset      in   synchronous, active-high reset
//   enable     in   sequencer run enable (0 freezes the phase)
//   load       in   program counter parallel-load request
//   nxt_adr    in   value loaded into the program counter when load=1
//   w_ram      in   RAM write enable (the write goes to crnt_adr)
//   ram_wdata  in   RAM write data
//   fetch      out  high in FETCH phase
//   decode     out  high in DECODE phase
//   execute    out  high in EXECUTE phase
//   crnt_adr   out  current program counter value, also the RAM address
//   value_out  out  RAM word at crnt_adr (asynchronous read)
// ---------------------------------------------------------------------------
module byteblast_fetch_core #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] nxt_adr,
    input  logic                  w_ram,
    input  logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  fetch,
    output logic                  decode,
    output logic                  execute,
    output logic [ADDR_WIDTH-1:0] crnt_adr,
    output logic [DATA_WIDTH-1:0] value_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        FETCH   = 3'b001,
        DECODE  = 3'b010,
        EXECUTE = 3'b100
    } phase_t;

    phase_t                phase_reg;
    logic [2:0]            phase_bits;
    logic [ADDR_WIDTH-1:0] pc_reg;

    // RAM array; left unreset so it can be preloaded and survives reset.
    logic [DATA_WIDTH-1:0] data [0:DEPTH-1];

    // -----------------------------------------------------------------------
    // Phase sequencer. The phase outputs are the one-hot state bits
    // themselves, so there is no combinational path from any input.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_reg <= FETCH;
        end else if (enable) begin
            case (phase_reg)
                FETCH:   phase_reg <= DECODE;
                DECODE:  phase_reg <= EXECUTE;
                EXECUTE: phase_reg <= FETCH;
                default: phase_reg <= FETCH;
            endcase
        end
    end

    assign phase_bits = phase_reg;
    assign fetch      = phase_bits[0];
    assign decode     = phase_bits[1];
    assign execute    = phase_bits[2];

    // -----------------------------------------------------------------------
    // Program counter. The increment is keyed off the fetch output, not off
    // enable: a sequencer frozen in FETCH keeps stepping the address.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= '0;
        end else if (load) begin
            pc_reg <= nxt_adr;
        end else if (fetch) begin
            pc_reg <= pc_reg + ADDR_WIDTH'(1);   // wraps modulo DEPTH
        end
    end

    assign crnt_adr = pc_reg;

    // -----------------------------------------------------------------------
    // RAM: synchronous write at the pre-edge address (independent of reset),
    // asynchronous read so value_out follows crnt_adr in the same cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_ram) begin
            data[pc_reg] <= ram_wdata;
        end
    end

    assign value_out = data[pc_reg];

endmodule

// File: tb/tb_byteblast_fetch_core.sv
// ---------------------------------------------------------------------------
// tb_byteblast_fetch_core
//
// Directed bench for byteblast_fetch_core. The RAM is preloaded through the
// hierarchy, then the bench steps the core edge by edge and compares phase,
// address and data against hand-computed values.
// ---------------------------------------------------------------------------
module tb_byteblast_fetch_core;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic                  load;
    logic [ADDR_WIDTH-1:0] nxt_adr;
    logic                  w_ram;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  fetch;
    logic                  decode;
    logic                  execute;
    logic [ADDR_WIDTH-1:0] crnt_adr;
    logic [DATA_WIDTH-1:0] value_out;

    int n_checks = 0;
    int n_fail   = 0;
    int n_edges  = 0;

    byteblast_fetch_core #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .nxt_adr   (nxt_adr),
        .w_ram     (w_ram),
        .ram_wdata (ram_wdata),
        .fetch     (fetch),
        .decode    (decode),
        .execute   (execute),
        .crnt_adr  (crnt_adr),
        .value_out (value_out)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] PH_F = 3'b001;
    localparam logic [2:0] PH_D = 3'b010;
    localparam logic [2:0] PH_E = 3'b100;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
        n_edges++;
        $display("edge %0d: phase(e,d,f)=%b adr=%0d value=0x%02h", n_edges,
                 {execute, decode, fetch}, crnt_adr, value_out);
    endtask

    task automatic check_state(input string tag, input logic [2:0] ph,
                               input logic [31:0] adr, input logic [31:0] val);
        check_eq({tag, ".phase"}, {29'd0, execute, decode, fetch}, {29'd0, ph});
        check_eq({tag, ".adr"}, {27'd0, crnt_adr}, adr);
        check_eq({tag, ".value"}, {24'd0, value_out}, val);
    endtask

    initial begin
        logic [2:0] exp_ph;
        int         exp_adr;
        logic [7:0] seq_val [0:4];

        reset = 1'b1; enable = 1'b1; load = 1'b0; nxt_adr = '0;
        w_ram = 1'b0; ram_wdata = '0;

        // Preload: 0..5 from the test program, the rest 0x10+index.
        for (int i = 0; i < 32; i++) dut.data[i] = 8'(8'h10 + i);
        dut.data[0] = 8'h23; dut.data[1] = 8'h44; dut.data[2] = 8'h85;
        dut.data[3] = 8'h02; dut.data[4] = 8'h05; dut.data[5] = 8'h00;
        seq_val[0] = 8'h23; seq_val[1] = 8'h44; seq_val[2] = 8'h85;
        seq_val[3] = 8'h02; seq_val[4] = 8'h05;

        // 1. Reset state.
        step();
        check_eq("rst.fetch", {31'd0, fetch}, 32'd1);
        check_eq("rst.decode", {31'd0, decode}, 32'd0);
        check_eq("rst.execute", {31'd0, execute}, 32'd0);
        check_state("rst", PH_F, 0, 32'h23);
        reset = 1'b0;

        // 2. Free run: phases D,E,F repeating, address steps every third edge.
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_ph  = (k % 3 == 1) ? PH_D : ((k % 3 == 2) ? PH_E : PH_F);
            exp_adr = (k + 2) / 3;
            check_state($sformatf("run%0d", k), exp_ph, exp_adr, {24'd0, seq_val[exp_adr]});
        end

        // 3. Load 31 on a FETCH edge, then wrap to 0 on the next fetch edge.
        load = 1'b1; nxt_adr = 5'd31;
        step();
        load = 1'b0;
        check_state("ld31", PH_D, 31, 32'h2F);
        step();
        check_state("ld31.e", PH_E, 31, 32'h2F);
        step();
        check_state("ld31.f", PH_F, 31, 32'h2F);
        step();
        check_state("wrap", PH_D, 0, 32'h23);

        // 4. Load 7 on a FETCH edge (beats the increment), then freeze in DECODE.
        step();
        step();
        check_state("pre.ld7", PH_F, 0, 32'h23);
        load = 1'b1; nxt_adr = 5'd7;
        step();
        load = 1'b0;
        check_state("ld7", PH_D, 7, 32'h17);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_state($sformatf("frzD%0d", k), PH_D, 7, 32'h17);
        end

        // 5. Write 0x07 at address 5 while in DECODE, then confirm it sticks.
        load = 1'b1; nxt_adr = 5'd5;
        step();
        load = 1'b0;
        check_state("ld5", PH_D, 5, 32'h00);
        w_ram = 1'b1; ram_wdata = 8'h07;
        step();
        w_ram = 1'b0;
        check_state("wr5", PH_D, 5, 32'h07);
        step();
        check_state("keep5", PH_D, 5, 32'h07);

        // Frozen in FETCH the address still advances every edge.
        enable = 1'b1;
        step();
        step();
        check_state("to.F", PH_F, 5, 32'h07);
        enable = 1'b0;
        step();
        check_state("frzF0", PH_F, 6, 32'h16);
        step();
        check_state("frzF1", PH_F, 7, 32'h17);

        // 6. Reset during EXECUTE at address 3.
        enable = 1'b1; load = 1'b1; nxt_adr = 5'd3;
        step();
        load = 1'b0;
        check_state("ld3", PH_D, 3, 32'h02);
        step();
        check_state("exe3", PH_E, 3, 32'h02);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_state("rst.exe", PH_F, 0, 32'h23);
        check_eq("ram5.kept", {24'd0, dut.data[5]}, 32'h07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
